// File: rtl/mist_audio_pkg.sv
// Shared types and parameter checks for the MiST serial audio transmitters.
// A parameter set that the checker rejects fails elaboration of the transmitter.
package mist_audio_pkg;

  typedef enum logic [1:0] {I2S, LJ, TDM} audio_mode_t;

  function automatic bit audio_params_ok(input int sampleWidth, input int slotBits,
                                         input int channels, input audio_mode_t mode,
                                         input int clkDiv);
    return (sampleWidth >= 8) && (sampleWidth <= 32) && (slotBits >= sampleWidth) &&
           (channels >= 2) && (channels <= 8) && ((mode == TDM) || (channels == 2)) &&
           (clkDiv >= 1);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock divider: bck toggles every CLK_DIV cycles, and fall_o flags the
// cycle whose closing edge takes bck from 1 to 0.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset,
  output logic bck_o,
  output logic fall_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] divCnt_q;
  logic          bck_q;
  logic          wrap;

  assign wrap = (divCnt_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      divCnt_q <= '0;
      bck_q    <= 1'b0;
    end else if (wrap) begin
      divCnt_q <= '0;
      bck_q    <= ~bck_q;
    end else begin
      divCnt_q <= divCnt_q + 1'b1;
    end
  end

  assign bck_o  = bck_q;
  assign fall_o = wrap & bck_q;

endmodule

// File: rtl/i2s_tdm_tx.sv
// Serial audio transmitter (I2S, left-justified or TDM) with a one-frame
// holding buffer; an empty buffer at frame start repeats the previous frame.
module i2s_tdm_tx
  import mist_audio_pkg::*;
#(
  parameter int          SAMPLE_WIDTH = 16,
  parameter int          SLOT_BITS    = 32,
  parameter int          CHANNELS     = 2,
  parameter audio_mode_t MODE         = I2S,
  parameter int          CLK_DIV      = 4
) (
  input  logic                             clk_sys,
  input  logic                             reset,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  output logic                             bck,
  output logic                             lrck,
  output logic                             sdata,
  output logic                             underrun
);

  localparam int DW = CHANNELS * SAMPLE_WIDTH;
  localparam int FW = CHANNELS * SLOT_BITS;
  localparam int BW = $clog2(FW);

  if (!audio_params_ok(SAMPLE_WIDTH, SLOT_BITS, CHANNELS, MODE, CLK_DIV)) begin : g_badParams
    $error("i2s_tdm_tx: illegal parameter combination");
  end

  // Lay samples out in transmit order: channel 0 in the top slot, each
  // sample left-aligned with zero padding below it.
  function automatic logic [FW-1:0] buildFrame(input logic [DW-1:0] samples);
    logic [FW-1:0] f;
    f = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      f[FW-1-c*SLOT_BITS -: SAMPLE_WIDTH] = samples[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
    return f;
  endfunction

  logic          fall;
  logic [BW-1:0] bitCnt_q;
  logic [DW-1:0] holdBuf_q;
  logic          holdFull_q;
  logic [DW-1:0] repFrame_q;
  logic [FW-1:0] shiftReg_q, shiftReg_d;
  logic          sdata_q, sdata_d;
  logic          lrck_q, lrck_d;
  logic          underrun_q;
  logic          frameStart;
  logic [FW-1:0] loadFrame;
  logic [FW-1:0] curFrame;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bck_o   (bck),
    .fall_o  (fall)
  );

  // bitCnt_q is the index of the bit that the next fall strobe starts.
  assign frameStart = (bitCnt_q == '0);

  // I2S shifts out the previous bit, giving the one-BCK lag behind lrck.
  always_comb begin
    loadFrame = buildFrame(holdFull_q ? holdBuf_q : repFrame_q);
    curFrame  = frameStart ? loadFrame : shiftReg_q;
    if (MODE == I2S) begin
      sdata_d    = shiftReg_q[FW-1];
      shiftReg_d = frameStart ? loadFrame : (shiftReg_q << 1);
    end else begin
      sdata_d    = curFrame[FW-1];
      shiftReg_d = curFrame << 1;
    end
    if (MODE == TDM) begin
      lrck_d = frameStart;
    end else begin
      lrck_d = (bitCnt_q >= BW'(SLOT_BITS));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bitCnt_q   <= '0;
      holdBuf_q  <= '0;
      holdFull_q <= 1'b0;
      repFrame_q <= '0;
      shiftReg_q <= '0;
      sdata_q    <= 1'b0;
      lrck_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= fall && frameStart && !holdFull_q;
      if (fall) begin
        bitCnt_q   <= (bitCnt_q == BW'(FW - 1)) ? '0 : bitCnt_q + 1'b1;
        shiftReg_q <= shiftReg_d;
        sdata_q    <= sdata_d;
        lrck_q     <= lrck_d;
        if (frameStart && holdFull_q) begin
          repFrame_q <= holdBuf_q;
          holdFull_q <= 1'b0;
        end
      end
      // Ready is low while full, so this never collides with the frame-start unload.
      if (sample_valid && !holdFull_q) begin
        holdBuf_q  <= sample_data;
        holdFull_q <= 1'b1;
      end
    end
  end

  assign sample_ready = ~holdFull_q;
  assign sdata        = sdata_q;
  assign lrck         = lrck_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench for i2s_tdm_tx: an I2S, an LJ and a TDM instance exercised
// in turn, with serial bits captured at each bck rising edge.
module tb_i2s_tdm_tx;
  import mist_audio_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checkCnt  = 0;
  int passCnt   = 0;
  int failCnt   = 0;
  int cyc       = 0;
  int acceptCnt = 0;
  int bpN       = 0;
  logic bpOn    = 1'b0;

  always @(posedge clk) cyc++;

  logic         resetA, resetB, resetC;
  logic         validA, validB, validC;
  logic [31:0]  dataA;
  logic [47:0]  dataB;
  logic [127:0] dataC;
  logic readyA, bckA, lrckA, sdataA, underrunA;
  logic readyB, bckB, lrckB, sdataB, underrunB;
  logic readyC, bckC, lrckC, sdataC, underrunC;

  i2s_tdm_tx #(.MODE(I2S)) dutA (
    .clk_sys(clk), .reset(resetA), .sample_data(dataA), .sample_valid(validA),
    .sample_ready(readyA), .bck(bckA), .lrck(lrckA), .sdata(sdataA), .underrun(underrunA));

  i2s_tdm_tx #(.SAMPLE_WIDTH(24), .SLOT_BITS(24), .CHANNELS(2), .MODE(LJ), .CLK_DIV(1)) dutB (
    .clk_sys(clk), .reset(resetB), .sample_data(dataB), .sample_valid(validB),
    .sample_ready(readyB), .bck(bckB), .lrck(lrckB), .sdata(sdataB), .underrun(underrunB));

  i2s_tdm_tx #(.SAMPLE_WIDTH(16), .SLOT_BITS(16), .CHANNELS(8), .MODE(TDM), .CLK_DIV(1)) dutC (
    .clk_sys(clk), .reset(resetC), .sample_data(dataC), .sample_valid(validC),
    .sample_ready(readyC), .bck(bckC), .lrck(lrckC), .sdata(sdataC), .underrun(underrunC));

  wire [2:0] bckV = {bckC, bckB, bckA};
  wire [2:0] sdV  = {sdataC, sdataB, sdataA};
  wire [2:0] lrV  = {lrckC, lrckB, lrckA};

  // Underrun pulse counters: total high cycles and rising edges per instance.
  int urHighA = 0, urRiseA = 0, urHighB = 0;
  logic urPrevA = 1'b0;
  always @(negedge clk) begin
    if (underrunA === 1'b1) urHighA++;
    if (underrunA === 1'b1 && urPrevA !== 1'b1) urRiseA++;
    urPrevA = underrunA;
    if (underrunB === 1'b1) urHighB++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeoutFail(input string tag);
    checkCnt++;
    failCnt++;
    $error("[TB] FAIL %s: observed timeout expected bck edge", tag);
  endtask

  task automatic applyStimulus(input int k, input logic [127:0] d, input logic v);
    case (k)
      0:       begin dataA = d[31:0]; validA = v; end
      1:       begin dataB = d[47:0]; validB = v; end
      default: begin dataC = d;       validC = v; end
    endcase
  endtask

  task automatic waitFall(input int k);
    int n = 0;
    while (bckV[k] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    do begin @(negedge clk); n++; end while (bckV[k] !== 1'b0 && n < 400);
    if (n >= 400) timeoutFail("waitFall");
  endtask

  task automatic getBit(input int k, output logic sd, output logic lr);
    int n = 0;
    while (bckV[k] !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    do begin @(negedge clk); n++; end while (bckV[k] !== 1'b1 && n < 400);
    if (n >= 400) timeoutFail("getBit");
    sd = sdV[k];
    lr = lrV[k];
  endtask

  task automatic captureFrame(input int k, input int nBits, output logic [127:0] sd,
                              output logic [127:0] lr, output int t0, output int tEnd);
    logic s, l;
    sd = '0; lr = '0; t0 = 0; tEnd = 0;
    for (int i = 0; i < nBits; i++) begin
      getBit(k, s, l);
      if (i == 0) t0 = cyc;
      tEnd = cyc;
      sd = {sd[126:0], s};
      lr = {lr[126:0], l};
    end
  endtask

  initial begin
    logic [127:0] sd, lr;
    logic [10:0]  part;
    logic         s, l;
    int t0, tEnd, t0b, tEndB;

    resetA = 1'b1; resetB = 1'b1; resetC = 1'b1;
    applyStimulus(0, '0, 1'b0);
    applyStimulus(1, '0, 1'b0);
    applyStimulus(2, '0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("A reset outputs", 128'({bckA, lrckA, sdataA, underrunA, readyA}), 128'(5'b00001));
    checkOutput("C reset outputs", 128'({bckC, lrckC, sdataC, underrunC, readyC}), 128'(5'b00001));

    // I2S: L=8001 R=7FFE, then three underrun frames repeating it.
    applyStimulus(0, 128'h7FFE_8001, 1'b1);
    resetA = 1'b0;
    @(negedge clk);
    validA = 1'b0;
    checkOutput("A ready after accept", 128'(readyA), 128'(1'b0));
    waitFall(0);
    captureFrame(0, 64, sd, lr, t0, tEnd);
    checkOutput("A I2S data", sd, 128'(64'h4000_8000_3FFF_0000));
    checkOutput("A I2S lrck", lr, 128'(64'h0000_0000_FFFF_FFFF));
    checkOutput("A bck period", 128'(tEnd - t0), 128'(504));
    checkOutput("A ready after load", 128'(readyA), 128'(1'b1));
    for (int f = 0; f < 3; f++) begin
      captureFrame(0, 64, sd, lr, t0, tEnd);
      checkOutput("A underrun repeat", sd, 128'(64'h4000_8000_3FFF_0000));
    end
    checkOutput("A underrun cycles", 128'(urHighA), 128'(3));
    checkOutput("A underrun pulses", 128'(urRiseA), 128'(3));

    // Back-pressure: valid held high, data advances after each accept.
    bpOn = 1'b1;
    applyStimulus(0, 128'h2000_1000, 1'b1);
    fork
      begin
        while (bpOn) begin
          @(posedge clk);
          if (bpOn && validA && readyA) begin
            acceptCnt++;
            bpN++;
            #1 dataA = {16'(16'h2000 + bpN), 16'(16'h1000 + bpN)};
          end
        end
      end
    join_none
    for (int f = 0; f < 4; f++) begin
      captureFrame(0, 64, sd, lr, t0, tEnd);
      checkOutput("A bp left", 128'(sd[62:47]), 128'(16'h1000 + f));
      checkOutput("A bp right", 128'(sd[30:15]), 128'(16'h2000 + f));
      checkOutput("A bp accepts", 128'(acceptCnt), 128'(2 + f));
      checkOutput("A bp ready low", 128'(readyA), 128'(1'b0));
    end
    bpOn = 1'b0;
    validA = 1'b0;
    checkOutput("A bp no underrun", 128'(urHighA), 128'(3));
    resetA = 1'b1;

    // LJ 24/24: L=A5A5A5 R=123456, CLK_DIV=1.
    applyStimulus(1, 128'h123456_A5A5A5, 1'b1);
    resetB = 1'b0;
    @(negedge clk);
    validB = 1'b0;
    waitFall(1);
    captureFrame(1, 48, sd, lr, t0, tEnd);
    checkOutput("B LJ data", sd, 128'(48'hA5A5A5_123456));
    checkOutput("B LJ lrck", lr, 128'(48'h000000_FFFFFF));
    captureFrame(1, 48, sd, lr, t0b, tEndB);
    checkOutput("B LJ repeat", sd, 128'(48'hA5A5A5_123456));
    checkOutput("B frame period", 128'(t0b - t0), 128'(96));
    checkOutput("B underrun count", 128'(urHighB), 128'(1));

    // Fill the buffer, then reset at bit 10 of the next frame.
    applyStimulus(1, 128'hFFFFFF_FFFFFF, 1'b1);
    @(negedge clk);
    validB = 1'b0;
    checkOutput("B ready full", 128'(readyB), 128'(1'b0));
    part = '0;
    for (int i = 0; i < 11; i++) begin
      getBit(1, s, l);
      part = {part[9:0], s};
    end
    checkOutput("B partial frame", 128'(part), 128'(11'h52D));
    resetB = 1'b1;
    @(negedge clk);
    checkOutput("B reset outputs", 128'({bckB, lrckB, sdataB, underrunB, readyB}), 128'(5'b00001));
    resetB = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("B restart strobe", 128'({bckB, underrunB}), 128'(2'b01));
    captureFrame(1, 48, sd, lr, t0, tEnd);
    checkOutput("B silence data", sd, 128'(0));
    checkOutput("B silence lrck", lr, 128'(48'h000000_FFFFFF));
    resetB = 1'b1;

    // TDM 8 x 16: channel n = 0x0100*n.
    applyStimulus(2, 128'h0700_0600_0500_0400_0300_0200_0100_0000, 1'b1);
    resetC = 1'b0;
    @(negedge clk);
    validC = 1'b0;
    waitFall(2);
    captureFrame(2, 128, sd, lr, t0, tEnd);
    checkOutput("C TDM data", sd, 128'h0000_0100_0200_0300_0400_0500_0600_0700);
    checkOutput("C TDM slot3", 128'(sd[79:64]), 128'(16'h0300));
    checkOutput("C TDM lrck", lr, {1'b1, 127'b0});
    captureFrame(2, 128, sd, lr, t0b, tEndB);
    checkOutput("C TDM lrck repeat", lr, {1'b1, 127'b0});
    checkOutput("C frame period", 128'(t0b - t0), 128'(256));

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
